// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO family: counter and pointer widths
// derived from the storage depth.
package fifo_pkg;

  // Width able to hold an occupancy count of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a read/write pointer into a depth-entry array (at least 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Pointer register that counts 0..MAX-1 and wraps back to 0 (modulo-MAX,
// so MAX need not be a power of two). clr_i returns the pointer to 0.
module mod_counter
  import fifo_pkg::*;
#(
  parameter int unsigned MAX = 6
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [ptr_w(MAX)-1:0]  val_o
);

  localparam int PW = ptr_w(MAX);
  localparam logic [PW-1:0] LAST = PW'(MAX - 1);

  logic [PW-1:0] r_val;

  // Reset/clear to zero, otherwise advance with an explicit wrap at MAX-1.
  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      r_val <= '0;
    end else if (inc_i) begin
      r_val <= (r_val == LAST) ? '0 : r_val + 1'b1;
    end
  end

  assign val_o = r_val;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock elastic FIFO with valid/ready on both sides, any depth,
// occupancy count, almost-full/almost-empty flags, synchronous flush and an
// optional zero-latency pass-through when empty.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (push = in_valid & in_ready, pop = out_valid & out_ready); ready
// never depends on the same side's valid, and a full FIFO refuses input even
// when a pop happens in the same cycle.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned DEPTH      = 6,
  parameter int unsigned BYPASS     = 0,
  parameter int unsigned AFULL_THR  = 5,
  parameter int unsigned AEMPTY_THR = 1
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       flush_i,
  input  logic [ELEM_WIDTH-1:0]      elem_in_i,
  input  logic                       elem_in_valid_i,
  output logic                       elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0]      elem_out_o,
  output logic                       elem_out_valid_o,
  input  logic                       elem_out_ready_i,
  output logic [cnt_w(DEPTH)-1:0]    count_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [CW-1:0]         r_count;
  logic [ELEM_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pass;
  logic                  w_pass_take;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_en;
  logic                  w_rd_inc;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Pass-through is offered only when nothing is stored, so ordering holds.
  assign w_pass = (BYPASS != 0) && w_empty && elem_in_valid_i;

  assign elem_in_ready_o  = !w_full;
  assign elem_out_valid_o = !w_empty || w_pass;
  assign elem_out_o       = w_pass ? elem_in_i : r_mem[w_rd_ptr];

  assign w_push = elem_in_valid_i && elem_in_ready_o;
  assign w_pop  = elem_out_valid_o && elem_out_ready_i;

  // A passed-through element consumed in the same cycle never touches storage.
  assign w_pass_take = w_pass && elem_out_ready_i;
  assign w_wr_en     = w_push && !w_pass_take && !flush_i;
  assign w_rd_inc    = w_pop  && !w_pass_take && !flush_i;

  mod_counter #(.MAX(DEPTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (flush_i),
    .inc_i  (w_wr_en),
    .val_o  (w_wr_ptr)
  );

  mod_counter #(.MAX(DEPTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (flush_i),
    .inc_i  (w_rd_inc),
    .val_o  (w_rd_ptr)
  );

  // Unreset storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_ptr] <= elem_in_i;
    end
  end

  // Occupancy: count + push - pop; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_inc);
    end
  end

  assign count_o        = r_count;
  assign almost_full_o  = (r_count >= CW'(AFULL_THR));
  assign almost_empty_o = (r_count <= CW'(AEMPTY_THR));

  // Simulation sanity checks on storage bookkeeping and threshold ordering.
  a_no_push_full : assert property (@(posedge clk_i) disable iff (srst_i) !(w_wr_en && w_full));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (srst_i) !(w_rd_inc && w_empty));
  a_count_range  : assert property (@(posedge clk_i) disable iff (srst_i) r_count <= CW'(DEPTH));
  a_thr_order    : assert property (@(posedge clk_i) AEMPTY_THR < AFULL_THR);

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: one registered instance (index 0) and one
// pass-through instance (index 1), each checked every cycle against a
// queue-based model of the FIFO rules, plus directed scenario checks.
module tb_sync_fifo_flex;

  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       srst;
  logic       flush [2];
  logic [7:0] din   [2];
  logic       vin   [2];
  logic       rdi   [2];
  logic       ordy  [2];
  logic [7:0] dout  [2];
  logic       vo    [2];
  logic [2:0] cnt   [2];
  logic       af    [2];
  logic       ae    [2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  bit         model_ok = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sync_fifo_flex #(.ELEM_WIDTH(8), .DEPTH(DEPTH), .BYPASS(0), .AFULL_THR(5), .AEMPTY_THR(1)) u_reg (
    .clk_i(clk), .srst_i(srst), .flush_i(flush[0]),
    .elem_in_i(din[0]), .elem_in_valid_i(vin[0]), .elem_in_ready_o(rdi[0]),
    .elem_out_o(dout[0]), .elem_out_valid_o(vo[0]), .elem_out_ready_i(ordy[0]),
    .count_o(cnt[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0])
  );

  sync_fifo_flex #(.ELEM_WIDTH(8), .DEPTH(DEPTH), .BYPASS(1), .AFULL_THR(5), .AEMPTY_THR(1)) u_byp (
    .clk_i(clk), .srst_i(srst), .flush_i(flush[1]),
    .elem_in_i(din[1]), .elem_in_valid_i(vin[1]), .elem_in_ready_o(rdi[1]),
    .elem_out_o(dout[1]), .elem_out_valid_o(vo[1]), .elem_out_ready_i(ordy[1]),
    .count_o(cnt[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1])
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one instance's outputs with what the model queue implies.
  task automatic check_one(input int s);
    int         sz;
    logic [7:0] head;
    bit         ev;
    head = 8'h00;
    if (s == 0) begin
      sz = exp_q0.size();
      if (sz > 0) head = exp_q0[0];
    end else begin
      sz = exp_q1.size();
      if (sz > 0) head = exp_q1[0];
    end
    ev = (sz > 0) || ((s == 1) && vin[s]);
    chk($sformatf("d%0d_in_ready", s), 32'(rdi[s]), 32'(sz < DEPTH));
    chk($sformatf("d%0d_out_valid", s), 32'(vo[s]), 32'(ev));
    if (ev) chk($sformatf("d%0d_out_data", s), 32'(dout[s]), (sz > 0) ? 32'(head) : 32'(din[s]));
    chk($sformatf("d%0d_count", s), 32'(cnt[s]), 32'(sz));
    chk($sformatf("d%0d_afull", s), 32'(af[s]), 32'(sz >= 5));
    chk($sformatf("d%0d_aempty", s), 32'(ae[s]), 32'(sz <= 1));
  endtask

  // Apply one clock edge's worth of FIFO rules to the model queue.
  task automatic upd(input int s);
    logic [7:0] q[$];
    int         sz;
    bit         push, pop;
    if (s == 0) q = exp_q0; else q = exp_q1;
    sz = q.size();
    if (srst || flush[s]) begin
      q.delete();
    end else begin
      push = vin[s] && (sz < DEPTH);
      pop  = ((sz > 0) || ((s == 1) && vin[s])) && ordy[s];
      if (pop && sz > 0) void'(q.pop_front());
      if (push && !(pop && sz == 0)) q.push_back(din[s]);
    end
    if (s == 0) exp_q0 = q; else exp_q1 = q;
  endtask

  // One cycle: inputs were driven after the falling edge; check, clock, update.
  task automatic tick();
    #2;
    if (model_ok) begin
      check_one(0);
      check_one(1);
    end
    @(posedge clk);
    upd(0);
    upd(1);
    if (srst) model_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive(input int s, input bit v, input logic [7:0] d, input bit r, input bit f);
    vin[s] = v; din[s] = d; ordy[s] = r; flush[s] = f;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    srst = 1'b1;
    drive(0, 1'b1, 8'hEE, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset held two cycles with input valid asserted
    tick();
    tick();
    srst = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("rst_count", 32'(cnt[0]), 32'd0);
    chk("rst_valid", 32'(vo[0]), 32'd0);
    chk("rst_ready", 32'(rdi[0]), 32'd1);
    chk("rst_aempty", 32'(ae[0]), 32'd1);
    chk("rst_afull", 32'(af[0]), 32'd0);

    // Fill: 0x10..0x15 with no pops, then one refused push
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      tick();
      #1;
      chk("fill_afull", 32'(af[0]), 32'(i + 1 >= 5));
    end
    #1;
    chk("fill_ready", 32'(rdi[0]), 32'd0);
    chk("fill_count", 32'(cnt[0]), 32'd6);
    drive(0, 1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    #1;
    chk("full_refuse_count", 32'(cnt[0]), 32'd6);
    chk("full_head", 32'(dout[0]), 32'h10);

    // Full with simultaneous push+pop: only the pop happens
    drive(0, 1'b1, 8'h16, 1'b1, 1'b0);
    tick();
    #1;
    chk("full_pop_count", 32'(cnt[0]), 32'd5);
    drive(0, 1'b1, 8'h16, 1'b0, 1'b0);
    tick();
    #1;
    chk("after_full_push", 32'(cnt[0]), 32'd6);

    // Drain completely
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end

    // Wrap: continuous push1/pop1 for 0x00..0x13, count stays at 1
    drive(0, 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    for (int i = 1; i < 20; i++) begin
      #1;
      chk("wrap_count", 32'(cnt[0]), 32'd1);
      chk("wrap_data", 32'(dout[0]), 32'(i - 1));
      drive(0, 1'b1, 8'(i), 1'b1, 1'b0);
      tick();
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();

    // Pass-through instance: empty, valid+ready -> same-cycle output, nothing stored
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b1, 8'hA5, 1'b1, 1'b0);
    #1;
    chk("byp_valid", 32'(vo[1]), 32'd1);
    chk("byp_data", 32'(dout[1]), 32'hA5);
    tick();
    #1;
    chk("byp_count0", 32'(cnt[1]), 32'd0);
    drive(1, 1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("byp_stored_count", 32'(cnt[1]), 32'd1);
    chk("byp_stored_data", 32'(dout[1]), 32'hA5);
    drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Flush at count 4 together with push and pop
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      tick();
    end
    drive(0, 1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("flush_count", 32'(cnt[0]), 32'd0);
    chk("flush_valid", 32'(vo[0]), 32'd0);
    drive(0, 1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("flush_first_out", 32'(dout[0]), 32'h3C);
    tick();

    // Random traffic on both instances, occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (c < 300)
          drive(s, ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 40) == 0));
        else
          drive(s, ($urandom_range(0, 1) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 40) == 0));
      end
      srst = ($urandom_range(0, 199) == 0);
      tick();
    end
    srst = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
